// File: rtl/tf32_operand_prep_pkg.sv
// tf32_pkg: shared widths, constants and packed types for the TF32 operand
// preparation block.
//   tf32_t    : 19-bit TF32 value {sign, exponent[7:0], mantissa[9:0]}
//   opflags_t : per-operand classification and rounding flags
package tf32_pkg;

   localparam int unsigned TF32_W   = 19;
   localparam int unsigned EXP_W    = 8;
   localparam int unsigned MAN_W    = 10;
   localparam int unsigned FP32_W   = 32;
   localparam int unsigned MAN_DROP = 13;

   localparam logic [TF32_W-1:0] TF32_QNAN = 19'h3FE00;
   localparam logic [EXP_W-1:0]  EXP_MAX   = 8'hFF;

   typedef struct packed {
      logic             s;
      logic [EXP_W-1:0] e;
      logic [MAN_W-1:0] m;
   } tf32_t;

   typedef struct packed {
      logic zero;
      logic inf;
      logic nan;
      logic inexact;
      logic ovf;
   } opflags_t;

endpackage

// File: rtl/fp32_to_tf32_cvt.sv
// fp32_to_tf32_cvt: combinational FP32 -> TF32 rounding and classification.
// Ports:
//   fp_i    [31:0] FP32 operand
//   tf_o    tf32_t rounded TF32 value (canonical QNaN for any NaN input)
//   flags_o opflags_t zero / inf / nan / inexact / ovf
// Parameters: RNE (1 = round-to-nearest-even, 0 = truncate), DAZ (must be 1).
module fp32_to_tf32_cvt
   import tf32_pkg::*;
#(
   parameter int unsigned RNE = 1,
   parameter int unsigned DAZ = 1
) (
   input  logic [FP32_W-1:0] fp_i,
   output tf32_t             tf_o,
   output opflags_t          flags_o
);

   if (DAZ != 1) begin : g_daz_chk
      $error("fp32_to_tf32_cvt: only DAZ=1 is supported");
   end

   logic                   s;
   logic [EXP_W-1:0]       e;
   logic [22:0]            m;
   logic [MAN_W-1:0]       keep;
   logic                   guard;
   logic                   sticky;
   logic                   up;
   logic [EXP_W+MAN_W-1:0] sum;

   assign s      = fp_i[31];
   assign e      = fp_i[30:23];
   assign m      = fp_i[22:0];
   assign keep   = m[22:MAN_DROP];
   assign guard  = m[MAN_DROP-1];
   assign sticky = |m[MAN_DROP-2:0];
   // keep[0] is the retained lsb; ties round toward an even mantissa
   assign up     = (RNE != 0) & guard & (sticky | keep[0]);
   // mantissa carry ripples into the exponent, which is the correct rounding
   assign sum    = {e, keep} + {{(EXP_W+MAN_W-1){1'b0}}, up};

   always_comb begin
      tf_o    = '0;
      flags_o = '0;
      if (e == '0) begin
         // zero or subnormal flushed to signed zero; never inexact
         tf_o.s       = s;
         flags_o.zero = 1'b1;
      end else if (e == EXP_MAX) begin
         if (m == '0) begin
            tf_o        = {s, EXP_MAX, {MAN_W{1'b0}}};
            flags_o.inf = 1'b1;
         end else begin
            tf_o        = TF32_QNAN;
            flags_o.nan = 1'b1;
         end
      end else begin
         flags_o.inexact = guard | sticky;
         if (sum[EXP_W+MAN_W-1:MAN_W] == EXP_MAX) begin
            tf_o        = {s, EXP_MAX, {MAN_W{1'b0}}};
            flags_o.ovf = 1'b1;
         end else begin
            tf_o = {s, sum};
         end
      end
   end

endmodule

// File: rtl/tf32_operand_prep.sv
// tf32_operand_prep: two-stage valid/ready pipeline that rounds an FP32
// operand pair to TF32 and precomputes the special-case product.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   in_valid/in_ready/in_a/in_b  input stream (FP32 pair)
//   out_valid/out_ready        output stream handshake
//   out_a/out_b                TF32 operands
//   out_special/out_special_val  replace multiplier result with this value
//   out_inexact/out_overflow   OR of per-operand rounding flags
module tf32_operand_prep
   import tf32_pkg::*;
#(
   parameter int unsigned RNE = 1,
   parameter int unsigned DAZ = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [FP32_W-1:0] in_a,
   input  logic [FP32_W-1:0] in_b,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [TF32_W-1:0] out_a,
   output logic [TF32_W-1:0] out_b,
   output logic              out_special,
   output logic [TF32_W-1:0] out_special_val,
   output logic              out_inexact,
   output logic              out_overflow
);

   tf32_t    cvt_a, cvt_b;
   opflags_t cvt_fa, cvt_fb;

   fp32_to_tf32_cvt #(.RNE(RNE), .DAZ(DAZ)) u_cvt_a (
      .fp_i(in_a), .tf_o(cvt_a), .flags_o(cvt_fa));
   fp32_to_tf32_cvt #(.RNE(RNE), .DAZ(DAZ)) u_cvt_b (
      .fp_i(in_b), .tf_o(cvt_b), .flags_o(cvt_fb));

   logic s1_load, s2_load;
   logic s1_v_q, s2_v_q;

   tf32_t    s1_a_q, s1_b_q;
   opflags_t s1_fa_q, s1_fb_q;

   tf32_t             s2_a_q, s2_b_q;
   logic              s2_sp_q;
   logic [TF32_W-1:0] s2_val_q;
   logic              s2_inx_q, s2_ovf_q;

   assign s2_load  = !s2_v_q | out_ready;
   assign s1_load  = !s1_v_q | s2_load;
   assign in_ready = s1_load;

   // Stage 1
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_v_q  <= 1'b0;
         s1_a_q  <= '0;
         s1_b_q  <= '0;
         s1_fa_q <= '0;
         s1_fb_q <= '0;
      end else if (s1_load) begin
         s1_v_q <= in_valid;
         if (in_valid) begin
            s1_a_q  <= cvt_a;
            s1_b_q  <= cvt_b;
            s1_fa_q <= cvt_fa;
            s1_fb_q <= cvt_fb;
         end
      end
   end

   // Special-case product; an overflowed operand behaves as infinity
   logic              inf_a, inf_b, nan_any, inf_any, zero_any, sp_s;
   logic              sp_d;
   logic [TF32_W-1:0] val_d;

   assign inf_a    = s1_fa_q.inf | s1_fa_q.ovf;
   assign inf_b    = s1_fb_q.inf | s1_fb_q.ovf;
   assign sp_s     = s1_a_q.s ^ s1_b_q.s;
   assign nan_any  = s1_fa_q.nan | s1_fb_q.nan
                   | (inf_a & s1_fb_q.zero) | (s1_fa_q.zero & inf_b);
   assign inf_any  = inf_a | inf_b;
   assign zero_any = s1_fa_q.zero | s1_fb_q.zero;

   always_comb begin
      sp_d  = 1'b0;
      val_d = '0;
      if (nan_any) begin
         sp_d  = 1'b1;
         val_d = TF32_QNAN;
      end else if (inf_any) begin
         sp_d  = 1'b1;
         val_d = {sp_s, EXP_MAX, {MAN_W{1'b0}}};
      end else if (zero_any) begin
         sp_d  = 1'b1;
         val_d = {sp_s, {(EXP_W+MAN_W){1'b0}}};
      end
   end

   // Stage 2
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_v_q   <= 1'b0;
         s2_a_q   <= '0;
         s2_b_q   <= '0;
         s2_sp_q  <= 1'b0;
         s2_val_q <= '0;
         s2_inx_q <= 1'b0;
         s2_ovf_q <= 1'b0;
      end else if (s2_load) begin
         s2_v_q <= s1_v_q;
         if (s1_v_q) begin
            s2_a_q   <= s1_a_q;
            s2_b_q   <= s1_b_q;
            s2_sp_q  <= sp_d;
            s2_val_q <= val_d;
            s2_inx_q <= s1_fa_q.inexact | s1_fb_q.inexact;
            s2_ovf_q <= s1_fa_q.ovf | s1_fb_q.ovf;
         end
      end
   end

   assign out_valid       = s2_v_q;
   assign out_a           = s2_a_q;
   assign out_b           = s2_b_q;
   assign out_special     = s2_sp_q;
   assign out_special_val = s2_val_q;
   assign out_inexact     = s2_inx_q;
   assign out_overflow    = s2_ovf_q;

endmodule
